// File: rtl/bombsquad_pkg.sv
// Shared types and helpers for the bomb time-entry front end.
package bombsquad_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } entry_state_t;

    localparam logic [1:0] DIGIT_HUNDREDS = 2'd2;
    localparam logic [1:0] DIGIT_TENS     = 2'd1;
    localparam logic [1:0] DIGIT_ONES     = 2'd0;

    // One BCD step with wrap-around; out-of-range inputs collapse to a legal digit.
    function automatic bcd_digit_t bcd_step(input bcd_digit_t digit, input logic up);
        bcd_digit_t result;
        if (up) begin
            result = (digit >= 4'd9) ? 4'd0 : digit + 4'd1;
        end else begin
            result = (digit == 4'd0 || digit > 4'd9) ? 4'd9 : digit - 4'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for an already-synchronized button level.
// History resets to 1 so a button held through reset yields no edge.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= btn;
        end
    end

    assign rise = btn & ~prev_q;

endmodule

// File: rtl/timer_entry.sv
// Operator time-entry front end: dial a 3-digit BCD time, commit it as init_time.
// Edits are frozen and aborted while the countdown holds lock high.
module timer_entry
    import bombsquad_pkg::*;
#(
    parameter logic [11:0] DEFAULT_TIME = 12'h300,
    parameter logic [11:0] MIN_TIME     = 12'h010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_next,
    input  logic        btn_set,
    input  logic        lock,
    output logic [11:0] init_time,
    output logic [11:0] work_time,
    output logic [1:0]  digit_sel,
    output logic        editing,
    output logic        time_valid,
    output logic        entry_err
);

    localparam int BTN_DOWN = 0;
    localparam int BTN_UP   = 1;
    localparam int BTN_NEXT = 2;
    localparam int BTN_SET  = 3;

    logic [3:0]   btn_level;
    logic [3:0]   btn_rise;
    logic [11:0]  work_up;
    logic [11:0]  work_dn;

    entry_state_t state_q;
    logic [11:0]  init_time_q;
    logic [11:0]  work_time_q;
    logic [1:0]   digit_sel_q;
    logic         editing_q;
    logic         time_valid_q;
    logic         entry_err_q;

    assign btn_level = {btn_set, btn_next, btn_up, btn_down};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            btn_edge u_edge (
                .clk   (clk),
                .reset (reset),
                .btn   (btn_level[gi]),
                .rise  (btn_rise[gi])
            );
        end
    endgenerate

    // Only the selected nibble steps; neighbours never see a carry or borrow.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit
            assign work_up[gi*4 +: 4] = (digit_sel_q == 2'(gi))
                ? bcd_step(work_time_q[gi*4 +: 4], 1'b1) : work_time_q[gi*4 +: 4];
            assign work_dn[gi*4 +: 4] = (digit_sel_q == 2'(gi))
                ? bcd_step(work_time_q[gi*4 +: 4], 1'b0) : work_time_q[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            init_time_q  <= DEFAULT_TIME;
            work_time_q  <= DEFAULT_TIME;
            digit_sel_q  <= DIGIT_HUNDREDS;
            editing_q    <= 1'b0;
            time_valid_q <= 1'b0;
            entry_err_q  <= 1'b0;
        end else begin
            time_valid_q <= 1'b0;
            entry_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!lock && btn_rise[BTN_NEXT]) begin
                        state_q     <= EDIT;
                        editing_q   <= 1'b1;
                        digit_sel_q <= DIGIT_HUNDREDS;
                        work_time_q <= init_time_q;
                    end
                end
                EDIT: begin
                    if (lock) begin
                        state_q     <= IDLE;
                        editing_q   <= 1'b0;
                        digit_sel_q <= DIGIT_HUNDREDS;
                        work_time_q <= init_time_q;
                    end else if (btn_rise[BTN_SET]) begin
                        // BCD ordering matches plain binary ordering of the 12 bits.
                        if (work_time_q >= MIN_TIME) begin
                            state_q      <= COMMIT;
                            editing_q    <= 1'b0;
                            digit_sel_q  <= DIGIT_HUNDREDS;
                            init_time_q  <= work_time_q;
                            time_valid_q <= 1'b1;
                        end else begin
                            entry_err_q <= 1'b1;
                        end
                    end else if (btn_rise[BTN_NEXT]) begin
                        digit_sel_q <= (digit_sel_q == DIGIT_ONES) ? DIGIT_HUNDREDS
                                                                   : digit_sel_q - 2'd1;
                    end else if (btn_rise[BTN_UP]) begin
                        work_time_q <= work_up;
                    end else if (btn_rise[BTN_DOWN]) begin
                        work_time_q <= work_dn;
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    editing_q <= 1'b0;
                end
            endcase
        end
    end

    assign init_time  = init_time_q;
    assign work_time  = work_time_q;
    assign digit_sel  = digit_sel_q;
    assign editing    = editing_q;
    assign time_valid = time_valid_q;
    assign entry_err  = entry_err_q;

endmodule

// File: tb/tb_timer_entry.sv
// Directed bench for timer_entry: table of button presses with hand-computed results,
// plus hand sequences for reset mid-edit and buttons held across reset.
module tb_timer_entry;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_up, btn_down, btn_next, btn_set, lock;
    logic [11:0] init_time, work_time;
    logic [1:0]  digit_sel;
    logic        editing, time_valid, entry_err;

    always #5 clk = ~clk;

    timer_entry #(
        .DEFAULT_TIME (12'h300),
        .MIN_TIME     (12'h010)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_next   (btn_next),
        .btn_set    (btn_set),
        .lock       (lock),
        .init_time  (init_time),
        .work_time  (work_time),
        .digit_sel  (digit_sel),
        .editing    (editing),
        .time_valid (time_valid),
        .entry_err  (entry_err)
    );

    // Button bit order: {up, down, next, set, lock}
    localparam logic [4:0] B0 = 5'b00000;
    localparam logic [4:0] BU = 5'b10000;
    localparam logic [4:0] BD = 5'b01000;
    localparam logic [4:0] BN = 5'b00100;
    localparam logic [4:0] BS = 5'b00010;
    localparam logic [4:0] BL = 5'b00001;

    typedef struct {
        logic [4:0]  btn;
        logic [11:0] work;
        logic [11:0] init;
        logic [1:0]  sel;
        logic        ed;
        logic        v;
        logic        e;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passes = 0;

    task automatic add(input logic [4:0] b, input logic [11:0] w, input logic [11:0] i,
                       input logic [1:0] s, input logic ed, input logic v, input logic e);
        vec_t t;
        t.btn = b; t.work = w; t.init = i; t.sel = s; t.ed = ed; t.v = v; t.e = e;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic [4:0] b);
        {btn_up, btn_down, btn_next, btn_set, lock} = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input vec_t x);
        logic [28:0] got, want;
        got  = {work_time, init_time, digit_sel, editing, time_valid, entry_err};
        want = {x.work, x.init, x.sel, x.ed, x.v, x.e};
        checks++;
        if (got == want) begin
            passes++;
        end else begin
            $display("FAIL %s[%0d] got work=%h init=%h sel=%0d ed=%b valid=%b err=%b required work=%h init=%h sel=%0d ed=%b valid=%b err=%b",
                     name, idx, work_time, init_time, digit_sel, editing, time_valid, entry_err,
                     x.work, x.init, x.sel, x.ed, x.v, x.e);
        end
    endtask

    task automatic expect_now(input string name, input int idx, input logic [11:0] w,
                              input logic [11:0] i, input logic [1:0] s, input logic ed);
        vec_t t;
        t.btn = B0; t.work = w; t.init = i; t.sel = s; t.ed = ed; t.v = 1'b0; t.e = 1'b0;
        check(name, idx, t);
    endtask

    initial begin
        vec_t rel;

        //  btn      work     init     sel  ed  v  e
        add(B0,      12'h300, 12'h300, 2,   0,  0, 0);  // reset state
        add(BU,      12'h300, 12'h300, 2,   0,  0, 0);  // up ignored in IDLE
        add(BS,      12'h300, 12'h300, 2,   0,  0, 0);  // set ignored in IDLE
        add(BN,      12'h300, 12'h300, 2,   1,  0, 0);
        add(BU,      12'h400, 12'h300, 2,   1,  0, 0);
        add(BU,      12'h500, 12'h300, 2,   1,  0, 0);
        add(BN,      12'h500, 12'h300, 1,   1,  0, 0);
        add(BD,      12'h590, 12'h300, 1,   1,  0, 0);  // tens 0 -> 9
        add(BS,      12'h590, 12'h590, 2,   0,  1, 0);  // commit
        add(BN,      12'h590, 12'h590, 2,   1,  0, 0);
        add(BN,      12'h590, 12'h590, 1,   1,  0, 0);
        add(BN,      12'h590, 12'h590, 0,   1,  0, 0);
        add(BD,      12'h599, 12'h590, 0,   1,  0, 0);  // ones 0 -> 9
        add(BU,      12'h590, 12'h590, 0,   1,  0, 0);  // ones 9 -> 0, tens kept
        add(BN,      12'h590, 12'h590, 2,   1,  0, 0);  // selection wraps
        add(BD,      12'h490, 12'h590, 2,   1,  0, 0);
        add(BU | BS, 12'h490, 12'h490, 2,   0,  1, 0);  // set wins, no increment
        add(BN,      12'h490, 12'h490, 2,   1,  0, 0);
        add(BU,      12'h590, 12'h490, 2,   1,  0, 0);
        add(BL,      12'h490, 12'h490, 2,   0,  0, 0);  // lock aborts edit
        add(BN | BL, 12'h490, 12'h490, 2,   0,  0, 0);  // next under lock ignored
        add(BN,      12'h490, 12'h490, 2,   1,  0, 0);
        add(BD,      12'h390, 12'h490, 2,   1,  0, 0);
        add(BD,      12'h290, 12'h490, 2,   1,  0, 0);
        add(BD,      12'h190, 12'h490, 2,   1,  0, 0);
        add(BD,      12'h090, 12'h490, 2,   1,  0, 0);
        add(BN,      12'h090, 12'h490, 1,   1,  0, 0);
        add(BU,      12'h000, 12'h490, 1,   1,  0, 0);
        add(BN,      12'h000, 12'h490, 0,   1,  0, 0);
        add(BU,      12'h001, 12'h490, 0,   1,  0, 0);
        add(BU,      12'h002, 12'h490, 0,   1,  0, 0);
        add(BU,      12'h003, 12'h490, 0,   1,  0, 0);
        add(BU,      12'h004, 12'h490, 0,   1,  0, 0);
        add(BU,      12'h005, 12'h490, 0,   1,  0, 0);
        add(BS,      12'h005, 12'h490, 0,   1,  0, 1);  // rejected: below minimum
        add(BU,      12'h006, 12'h490, 0,   1,  0, 0);
        add(BU,      12'h007, 12'h490, 0,   1,  0, 0);
        add(BU,      12'h008, 12'h490, 0,   1,  0, 0);
        add(BU,      12'h009, 12'h490, 0,   1,  0, 0);
        add(BS,      12'h009, 12'h490, 0,   1,  0, 1);  // just below minimum
        add(BN,      12'h009, 12'h490, 2,   1,  0, 0);
        add(BN,      12'h009, 12'h490, 1,   1,  0, 0);
        add(BU,      12'h019, 12'h490, 1,   1,  0, 0);
        add(BN,      12'h019, 12'h490, 0,   1,  0, 0);
        add(BU,      12'h010, 12'h490, 0,   1,  0, 0);
        add(BS,      12'h010, 12'h010, 2,   0,  1, 0);  // exactly minimum accepted
        add(B0,      12'h010, 12'h010, 2,   0,  0, 0);

        reset = 1'b1;
        drive(B0);
        repeat (3) tick();
        reset = 1'b0;

        // Each row: drive for one cycle and check, then release and check pulses cleared.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].btn);
            tick();
            check("press", i, vecs[i]);
            drive(B0);
            tick();
            rel = vecs[i];
            rel.v = 1'b0;
            rel.e = 1'b0;
            check("release", i, rel);
        end

        // Enter edit and change a digit, then reset mid-edit with buttons held.
        drive(BN); tick(); drive(B0); tick();
        drive(BU); tick(); drive(B0); tick();
        expect_now("edit_before_reset", 0, 12'h110, 12'h010, 2, 1);

        drive(BN | BU | BS);
        reset = 1'b1;
        tick();
        expect_now("reset_mid_edit", 0, 12'h300, 12'h300, 2, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_now("held_over_reset", i, 12'h300, 12'h300, 2, 0);
        end
        drive(B0);
        tick();
        expect_now("held_released", 0, 12'h300, 12'h300, 2, 0);
        drive(BN);
        tick();
        expect_now("edit_after_reset", 0, 12'h300, 12'h300, 2, 1);
        drive(B0);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
